hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/hilo_muldiv_if.sv | 26 ++
 rtl/divider_core.sv | 58 +++++
 rtl/hilo_muldiv.sv | 110 +++++++++++
 tb/tb_hilo_muldiv.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct codes, state encoding and product helper for hilo_muldiv
package muldiv_pkg;

   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   localparam logic [1:0] MT_WRITE = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      DIV  = 1'b1
   } muldiv_state_e;

   // 64-bit product; sign extension to 64 bits makes the truncated product correct for MULT
   function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                         input logic is_signed);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = {(is_signed ? {32{a[31]}} : 32'h0), a};
      eb = {(is_signed ? {32{b[31]}} : 32'h0), b};
      return ea * eb;
   endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - issue/result bundle between the pipeline and the HI/LO unit
interface hilo_muldiv_if;
   import muldiv_pkg::*;

   logic        start;
   logic [5:0]  funct;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [1:0]  HI_write;
   logic [1:0]  LO_write;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   modport master (
      output start, funct, rs_data, rt_data, HI_write, LO_write,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, funct, rs_data, rt_data, HI_write, LO_write,
      output hi, lo, busy, done
   );

endinterface

// File: rtl/divider_core.sv
// rtl/divider_core.sv - unsigned restoring divider, one quotient bit per step, MSB first
module divider_core (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        last
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] div_q;
   logic [5:0]  cnt_q;

   logic [32:0] shifted;
   logic [31:0] rem_n;
   logic [31:0] quo_n;

   // Next partial remainder/quotient; the result fits in 32 bits whenever we subtract
   always_comb begin
      shifted = {rem_q, quo_q[31]};
      rem_n   = shifted[31:0];
      quo_n   = {quo_q[30:0], 1'b0};
      if (shifted >= {1'b0, div_q}) begin
         rem_n = shifted[31:0] - div_q;
         quo_n = {quo_q[30:0], 1'b1};
      end
   end

   // Outputs are the post-step values so the parent can capture them on the final edge
   assign quotient  = quo_n;
   assign remainder = rem_n;
   assign last      = (cnt_q == 6'd31);

   // Load operands on issue, then advance one iteration per step
   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= 32'h0;
         quo_q <= 32'h0;
         div_q <= 32'h0;
         cnt_q <= 6'd0;
      end else if (load) begin
         rem_q <= 32'h0;
         quo_q <= dividend;
         div_q <= divisor;
         cnt_q <= 6'd0;
      end else if (step) begin
         rem_q <= rem_n;
         quo_q <= quo_n;
         cnt_q <= cnt_q + 6'd1;
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register unit with single-cycle multiply and 32-cycle divide
module hilo_muldiv
   import muldiv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   hilo_muldiv_if.slave      bus
);

   muldiv_state_e state;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic          done_q;

   logic          q_neg;
   logic          r_neg;
   logic          b_zero;
   logic [31:0]   a_orig;

   logic          is_mul;
   logic          is_div;
   logic          accept;
   logic          div_signed;
   logic [31:0]   abs_a;
   logic [31:0]   abs_b;
   logic [63:0]   product;

   logic [31:0]   core_quo;
   logic [31:0]   core_rem;
   logic          core_last;
   logic [31:0]   quo_fix;
   logic [31:0]   rem_fix;

   // Decode the issue; only IDLE accepts a recognised funct
   always_comb begin
      is_mul     = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
      is_div     = (bus.funct == FUNCT_DIV)  || (bus.funct == FUNCT_DIVU);
      accept     = (state == IDLE) && bus.start && (is_mul || is_div);
      div_signed = (bus.funct == FUNCT_DIV);
      abs_a      = (div_signed && bus.rs_data[31]) ? (32'h0 - bus.rs_data) : bus.rs_data;
      abs_b      = (div_signed && bus.rt_data[31]) ? (32'h0 - bus.rt_data) : bus.rt_data;
      product    = mul64(bus.rs_data, bus.rt_data, bus.funct == FUNCT_MULT);
   end

   divider_core u_core (
      .clk       (clk),
      .reset     (reset),
      .load      (accept && is_div),
      .step      (state == DIV),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (core_quo),
      .remainder (core_rem),
      .last      (core_last)
   );

   // Sign fix-up; divide by zero bypasses it so hi keeps the original signed dividend
   always_comb begin
      quo_fix = q_neg ? (32'h0 - core_quo) : core_quo;
      rem_fix = r_neg ? (32'h0 - core_rem) : core_rem;
      if (b_zero) begin
         quo_fix = 32'hFFFF_FFFF;
         rem_fix = a_orig;
      end
   end

   // State, HI/LO and done; the division result is assigned last so it overrides a concurrent MT write
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         hi_q   <= 32'h0;
         lo_q   <= 32'h0;
         done_q <= 1'b0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         b_zero <= 1'b0;
         a_orig <= 32'h0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            if (is_mul) begin
               hi_q   <= product[63:32];
               lo_q   <= product[31:0];
               done_q <= 1'b1;
            end else begin
               q_neg  <= div_signed && (bus.rs_data[31] ^ bus.rt_data[31]);
               r_neg  <= div_signed && bus.rs_data[31];
               b_zero <= (bus.rt_data == 32'h0);
               a_orig <= bus.rs_data;
               state  <= DIV;
            end
         end else begin
            if (bus.HI_write == MT_WRITE) hi_q <= bus.rs_data;
            if (bus.LO_write == MT_WRITE) lo_q <= bus.rs_data;
            if ((state == DIV) && core_last) begin
               hi_q   <= rem_fix;
               lo_q   <= quo_fix;
               done_q <= 1'b1;
               state  <= IDLE;
            end
         end
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.done = done_q;
   assign bus.busy = (state == DIV);

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv
module tb_hilo_muldiv;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc;
   int   dones;

   hilo_muldiv_if bus ();

   hilo_muldiv dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start    = 1'b0;
      bus.funct    = 6'h00;
      bus.rs_data  = 32'h0;
      bus.rt_data  = 32'h0;
      bus.HI_write = 2'b00;
      bus.LO_write = 2'b00;
   endtask

   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.start   = 1'b1;
      bus.funct   = f;
      bus.rs_data = a;
      bus.rt_data = b;
      tick();
      idle_inputs();
   endtask

   // Counts busy cycles after an issue (bounded) and leaves time just after the completion edge
   task automatic wait_div(output int n);
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      check("reset_hi", bus.hi, 32'h0);
      check("reset_lo", bus.lo, 32'h0);
      check("reset_busy", {31'h0, bus.busy}, 32'h0);
      check("reset_done", {31'h0, bus.done}, 32'h0);
      reset = 1'b0;
      tick();

      // MTHI / MTLO and a non-11 encoding
      bus.HI_write = 2'b11; bus.rs_data = 32'h1234_5678;
      tick();
      idle_inputs();
      check("mthi_hi", bus.hi, 32'h1234_5678);
      bus.LO_write = 2'b11; bus.rs_data = 32'hCAFE_F00D;
      tick();
      idle_inputs();
      check("mtlo_lo", bus.lo, 32'hCAFE_F00D);
      check("mtlo_hi_kept", bus.hi, 32'h1234_5678);
      bus.LO_write = 2'b01; bus.rs_data = 32'h0;
      tick();
      idle_inputs();
      check("mtlo_01_ignored", bus.lo, 32'hCAFE_F00D);
      check("mt_no_done", {31'h0, bus.done}, 32'h0);

      // MULT -3 * 5
      issue(FUNCT_MULT, 32'hFFFF_FFFD, 32'd5);
      check("mult_hi", bus.hi, 32'hFFFF_FFFF);
      check("mult_lo", bus.lo, 32'hFFFF_FFF1);
      check("mult_done", {31'h0, bus.done}, 32'h1);
      check("mult_busy", {31'h0, bus.busy}, 32'h0);
      tick();
      check("mult_done_pulse", {31'h0, bus.done}, 32'h0);

      // MULTU max * max
      issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_hi", bus.hi, 32'hFFFF_FFFE);
      check("multu_lo", bus.lo, 32'h0000_0001);

      // Unrecognised funct is ignored
      tick();
      issue(6'h10, 32'h5, 32'h7);
      check("bad_funct_busy", {31'h0, bus.busy}, 32'h0);
      check("bad_funct_done", {31'h0, bus.done}, 32'h0);
      check("bad_funct_hi", bus.hi, 32'hFFFF_FFFE);

      // DIV -7 / 2
      issue(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_div(cyc);
      check("div_busy_cycles", cyc, 32);
      check("div_done", {31'h0, bus.done}, 32'h1);
      check("div_lo", bus.lo, 32'hFFFF_FFFD);
      check("div_hi", bus.hi, 32'hFFFF_FFFF);
      tick();
      check("div_done_pulse", {31'h0, bus.done}, 32'h0);

      // DIVU 100 / 0 with an MTHI while busy
      issue(FUNCT_DIVU, 32'd100, 32'd0);
      tick();
      bus.HI_write = 2'b11; bus.rs_data = 32'h0000_DEAD;
      tick();
      idle_inputs();
      check("mthi_busy_hi", bus.hi, 32'h0000_DEAD);
      check("mthi_busy_busy", {31'h0, bus.busy}, 32'h1);
      wait_div(cyc);
      check("divu0_cycles", cyc + 2, 32);
      check("divu0_hi", bus.hi, 32'h0000_0064);
      check("divu0_lo", bus.lo, 32'hFFFF_FFFF);
      tick();

      // Signed overflow
      issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_div(cyc);
      check("ovf_lo", bus.lo, 32'h8000_0000);
      check("ovf_hi", bus.hi, 32'h0000_0000);
      tick();

      // Signed divide by zero keeps the negative dividend in hi
      issue(FUNCT_DIV, 32'hFFFF_FFFB, 32'h0);
      wait_div(cyc);
      check("div0s_cycles", cyc, 32);
      check("div0s_hi", bus.hi, 32'hFFFF_FFFB);
      check("div0s_lo", bus.lo, 32'hFFFF_FFFF);
      tick();

      // Start and MTHI together: start wins
      bus.HI_write = 2'b11;
      issue(FUNCT_MULTU, 32'd2, 32'd3);
      check("start_wins_hi", bus.hi, 32'h0);
      check("start_wins_lo", bus.lo, 32'd6);
      tick();

      // DIVU 50/7, second start at iteration 5, reset at iteration 10
      issue(FUNCT_DIVU, 32'd50, 32'd7);
      for (int i = 0; i < 4; i++) tick();
      issue(FUNCT_MULT, 32'd1, 32'd1);
      check("busy_start_busy", {31'h0, bus.busy}, 32'h1);
      check("busy_start_lo", bus.lo, 32'd6);
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      bus.start = 1'b1; bus.funct = FUNCT_MULT; bus.rs_data = 32'd9; bus.rt_data = 32'd9;
      bus.LO_write = 2'b11;
      tick();
      reset = 1'b0;
      idle_inputs();
      check("abort_busy", {31'h0, bus.busy}, 32'h0);
      check("abort_hi", bus.hi, 32'h0);
      check("abort_lo", bus.lo, 32'h0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) dones++;
         tick();
      end
      check("abort_no_done", dones, 0);
      check("abort_lo_later", bus.lo, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
